// File: rtl/cla_serial_add_ctrl.sv
// rtl/cla_serial_add_ctrl.sv - two-requester adder sequenced over one shared carry-lookahead slice
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   reqX_valid / reqX_ready         requester X handshake (X = 0, 1)
//   reqX_a, reqX_b, reqX_cin        requester X operands and carry-in
//   out_valid / out_ready           result handshake
//   out_sum, out_cout, out_ovf      A+B+Cin (mod 2^DATA_W), carry out, signed overflow
//   out_id                          requester that owns the result
module cla_serial_add_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_id
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_width
      $error("cla_serial_add_ctrl: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, b_q, sum_q;
  logic               carry_q, cout_q, ovf_q, id_q, last_grant_q;

  logic               grant, accept, last_slice;
  logic [IDX_W-1:0]   base;
  logic [SLICE_W-1:0] slice_a, slice_b, g, p, slice_s;
  logic [SLICE_W:0]   c;
  logic               term, acc;

  // With nobody valid the grant points at the requester that would win next,
  // so exactly one ready is high in IDLE.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && !grant;
  assign req1_ready = (state_q == IDLE) && grant;
  assign accept     = (state_q == IDLE) && (grant ? req1_valid : req0_valid);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  assign base    = IDX_W'(cnt_q) * IDX_W'(SLICE_W);
  assign slice_a = a_q[base +: SLICE_W];
  assign slice_b = b_q[base +: SLICE_W];
  assign g       = slice_a & slice_b;
  assign p       = slice_a | slice_b;

  // Flattened lookahead: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]c[0].
  // carry_q holds cin for slice 0 (loaded at accept) and the previous
  // slice carry-out afterwards.
  always_comb begin
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE_W; i++) begin
      term = carry_q;
      for (int j = 0; j <= i; j++) term = term & p[j];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign slice_s = slice_a ^ slice_b ^ c[SLICE_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (last_slice) state_d = DONE;
           else            cnt_d   = cnt_q + 1'b1;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q          <= grant ? req1_a : req0_a;
        b_q          <= grant ? req1_b : req0_b;
        carry_q      <= grant ? req1_cin : req0_cin;
        id_q         <= grant;
        last_grant_q <= grant;
      end else if (state_q == RUN) begin
        sum_q[base +: SLICE_W] <= slice_s;
        carry_q                <= c[SLICE_W];
        if (last_slice) begin
          cout_q <= c[SLICE_W];
          ovf_q  <= c[SLICE_W-1] ^ c[SLICE_W];
        end
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb/tb_cla_serial_add_ctrl.sv - directed scoreboard bench for cla_serial_add_ctrl
module tb_cla_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_id;
  logic [31:0] out_sum;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        id;
  } exp_t;

  exp_t sb[$];

  cla_serial_add_ctrl #(.DATA_W(32), .SLICE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_id(out_id)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    exp_t m;
    logic [32:0] f;
    f      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    m.sum  = f[31:0];
    m.cout = f[32];
    m.ovf  = (a[31] == b[31]) && (f[31] != a[31]);
    m.id   = id;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    chk("grant_ready", id ? req1_ready : req0_ready, 1);
    chk("other_ready", id ? req0_ready : req1_ready, 0);
    sb.push_back(model(id, a, b, cin));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Operands change after accept; the DUT must not resample them.
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
      if (!out_valid) chk("run_no_ready", {req0_ready, req1_ready}, 0);
    end
    chk("latency", lat, 8);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("out_valid", out_valid, 1);
      chk("out_sum", out_sum, e.sum);
      chk("out_cout", out_cout, e.cout);
      chk("out_ovf", out_ovf, e.ovf);
      chk("out_id", out_id, e.id);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    issue(id, a, b, cin);
    wait_done();
    check_out();
    handshake();
  endtask

  initial begin
    logic [31:0] fa0 [4];
    logic [31:0] fb0 [4];
    logic [31:0] fa1 [4];
    logic [31:0] fb1 [4];
    int          k0, k1, who;
    exp_t        e;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, full-carry and overflow cases; last grant ends on requester 1.
    do_op(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Both requesters valid continuously: grants must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      fa0[i] = $urandom; fb0[i] = $urandom;
      fa1[i] = $urandom; fb1[i] = $urandom;
    end
    k0 = 0; k1 = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = fa0[0]; req0_b = fb0[0]; req0_cin = 1'b1;
    req1_valid = 1'b1; req1_a = fa1[0]; req1_b = fb1[0]; req1_cin = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_one_ready", req0_ready & req1_ready, 0);
      chk("rr_some_ready", req0_ready | req1_ready, 1);
      who = int'(req1_ready);
      chk("rr_grant", who, i % 2);
      if (who == 1) sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
      else          sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
      @(posedge clk);
      @(negedge clk);
      if (who == 1) begin
        k1++; req1_a = fa1[k1]; req1_b = fb1[k1];
      end else begin
        k0++; req0_a = fa0[k0]; req0_b = fb0[k0];
      end
      wait_done();
      check_out();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rr_valid_drop", out_valid, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;

    // Backpressure: hold DONE for 5 clocks with both requesters asking.
    issue(1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    wait_done();
    e = sb[0];
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, e.sum);
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_idle_req1_ready", req1_ready, 1);
    chk("bp_sum_held", out_sum, e.sum);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset at cnt==3: outputs clear without a clock edge, no result appears.
    issue(1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_sum", out_sum, 0);
    chk("arst_out_id", out_id, 0);
    chk("arst_out_valid", out_valid, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done();
    chk("post_rst_sum_const", out_sum, 32'h2345_6789);
    check_out();
    handshake();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
